// File: rtl/move_list_fetcher.sv
// Avalon-MM master that loads a board into the chess control slave, waits for the search
// to finish and streams the resulting move list out. Define MOVE_SENTINEL_CHECK_EN for the sentinel read.
module move_list_fetcher #(
   parameter int POLL_GAP  = 4,
   parameter int TIMEOUT   = 65535,
   parameter int MAX_MOVES = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [255:0] bstate_in,
   input  logic         go,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [7:0]   move_count,
   output logic [17:0]  move_data,
   output logic         move_valid,
   input  logic         move_ready,
   output logic         move_last,
   output logic [14:0]  master_address,
   output logic         master_read,
   output logic         master_write,
   output logic [31:0]  master_writedata,
   input  logic [31:0]  master_readdata,
   input  logic         master_waitrequest,
   input  logic         master_readdatavalid
);

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int PW = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
   localparam logic [PW-1:0] TO_VAL   = PW'(TIMEOUT);
   localparam logic [7:0]    MAX_CNT  = 8'(MAX_MOVES);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_BOARD, S_WR_START, S_POLL_WAIT, S_POLL,
      S_RD_COUNT, S_RD_MOVE, S_CLR_START, S_FIN
`ifdef MOVE_SENTINEL_CHECK_EN
      , S_RD_SENT
`endif
   } state_t;

`ifdef MOVE_SENTINEL_CHECK_EN
   localparam state_t S_AFTER_MOVES = S_RD_SENT;
`else
   localparam state_t S_AFTER_MOVES = S_CLR_START;
   logic unused_rdata;
   assign unused_rdata = ^master_readdata[31:18];
`endif

   state_t         state_q, state_d;
   logic [255:0]   board_q, board_d;
   logic [2:0]     k_q, k_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic [PW-1:0]  poll_q, poll_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [7:0]     idx_q, idx_d;
   logic           error_q, error_d;
   logic [14:0]    addr_q, addr_d;
   logic           rd_q, rd_d;
   logic           wr_q, wr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           pend_q, pend_d;
   logic [17:0]    mdata_q, mdata_d;
   logic           mvalid_q, mvalid_d;
   logic           mlast_q, mlast_d;

   logic          bus_idle, wr_done, rd_acc, rd_data, mv_take;
   logic [PW-1:0] poll_inc;
   logic [7:0]    count_clamped;

   function automatic logic [7:0] clamp_count(input logic [7:0] raw);
      return (raw > MAX_CNT) ? MAX_CNT : raw;
   endfunction

   assign bus_idle      = !rd_q && !wr_q && !pend_q;
   assign wr_done       = wr_q && !master_waitrequest;
   assign rd_acc        = rd_q && !master_waitrequest;
   assign rd_data       = pend_q && master_readdatavalid;
   assign mv_take       = mvalid_q && move_ready;
   assign poll_inc      = poll_q + 1'b1;
   assign count_clamped = clamp_count(master_readdata[7:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         board_q  <= '0;
         k_q      <= '0;
         gap_q    <= '0;
         poll_q   <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         error_q  <= 1'b0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wdata_q  <= '0;
         pend_q   <= 1'b0;
         mdata_q  <= '0;
         mvalid_q <= 1'b0;
         mlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         k_q      <= k_d;
         gap_q    <= gap_d;
         poll_q   <= poll_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         error_q  <= error_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         wdata_q  <= wdata_d;
         pend_q   <= pend_d;
         mdata_q  <= mdata_d;
         mvalid_q <= mvalid_d;
         mlast_q  <= mlast_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (go) state_d = S_WR_BOARD;
         S_WR_BOARD:  if (wr_done && k_q == 3'd7) state_d = S_WR_START;
         S_WR_START:  if (wr_done) state_d = S_POLL_WAIT;
         S_POLL_WAIT: if (gap_q == GAP_LAST) state_d = S_POLL;
         S_POLL: begin
            if (rd_data) begin
               if (master_readdata[1])     state_d = S_RD_COUNT;
               else if (poll_inc == TO_VAL) state_d = S_CLR_START;
               else                         state_d = S_POLL_WAIT;
            end
         end
         S_RD_COUNT:  if (rd_data) state_d = (count_clamped == 8'd0) ? S_AFTER_MOVES : S_RD_MOVE;
         S_RD_MOVE:   if (mv_take && mlast_q) state_d = S_AFTER_MOVES;
`ifdef MOVE_SENTINEL_CHECK_EN
         S_RD_SENT:   if (rd_data) state_d = S_CLR_START;
`endif
         S_CLR_START: if (wr_done) state_d = S_FIN;
         S_FIN:       state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Each bus state issues its command once the bus is idle; completion is seen in the same state.
   always_comb begin
      board_d  = board_q;
      k_d      = k_q;
      gap_d    = gap_q;
      poll_d   = poll_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      error_d  = error_q;
      addr_d   = addr_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      wdata_d  = wdata_q;
      pend_d   = pend_q;
      mdata_d  = mdata_q;
      mvalid_d = mvalid_q;
      mlast_d  = mlast_q;
      if (rd_acc) begin
         rd_d   = 1'b0;
         pend_d = 1'b1;
      end
      if (wr_done) wr_d = 1'b0;
      if (rd_data) pend_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               board_d = bstate_in;
               error_d = 1'b0;
               k_d     = '0;
               poll_d  = '0;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         S_WR_BOARD: begin
            if (bus_idle) begin
               wr_d    = 1'b1;
               addr_d  = 15'd2 + {12'd0, k_q};
               wdata_d = board_q[{k_q, 5'd0} +: 32];
            end
            if (wr_done) k_d = k_q + 3'd1;
         end
         S_WR_START: begin
            if (bus_idle) begin
               wr_d    = 1'b1;
               addr_d  = 15'd0;
               wdata_d = 32'h0000_0001;
            end
            if (wr_done) gap_d = '0;
         end
         S_POLL_WAIT: gap_d = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
         S_POLL: begin
            if (bus_idle) begin
               rd_d   = 1'b1;
               addr_d = 15'd0;
            end
            if (rd_data && !master_readdata[1]) begin
               poll_d = poll_inc;
               if (poll_inc == TO_VAL) error_d = 1'b1;
            end
         end
         S_RD_COUNT: begin
            if (bus_idle) begin
               rd_d   = 1'b1;
               addr_d = 15'd16;
            end
            if (rd_data) begin
               cnt_d = count_clamped;
               idx_d = '0;
            end
         end
         S_RD_MOVE: begin
            // One-entry buffer: the next read waits until the held move is accepted.
            if (bus_idle && !mvalid_q) begin
               rd_d   = 1'b1;
               addr_d = 15'd17 + {7'd0, idx_q};
            end
            if (rd_data) begin
               mdata_d  = master_readdata[17:0];
               mvalid_d = 1'b1;
               mlast_d  = (idx_q == cnt_q - 8'd1);
            end
            if (mv_take) begin
               mvalid_d = 1'b0;
               mlast_d  = 1'b0;
               idx_d    = idx_q + 8'd1;
            end
         end
`ifdef MOVE_SENTINEL_CHECK_EN
         S_RD_SENT: begin
            if (bus_idle) begin
               rd_d   = 1'b1;
               addr_d = 15'd17 + {7'd0, cnt_q};
            end
            if (rd_data && master_readdata != 32'd0) error_d = 1'b1;
         end
`endif
         S_CLR_START: begin
            if (bus_idle) begin
               wr_d    = 1'b1;
               addr_d  = 15'd0;
               wdata_d = 32'h0000_0000;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy             = (state_q != S_IDLE) && (state_q != S_FIN);
      done             = (state_q == S_FIN);
      error            = error_q;
      move_count       = cnt_q;
      move_data        = mdata_q;
      move_valid       = mvalid_q;
      move_last        = mlast_q;
      master_address   = addr_q;
      master_read      = rd_q;
      master_write     = wr_q;
      master_writedata = wdata_q;
   end

endmodule

// File: tb/tb_move_list_fetcher.sv
// Bench for move_list_fetcher: Avalon slave model with a transaction scoreboard and a move-stream scoreboard.
`timescale 1ns/1ps
module tb_move_list_fetcher;

   localparam int POLL_GAP  = 4;
   localparam int TIMEOUT   = 5;
   localparam int MAX_MOVES = 255;
`ifdef MOVE_SENTINEL_CHECK_EN
   localparam bit SENT_EN = 1'b1;
`else
   localparam bit SENT_EN = 1'b0;
`endif

   typedef struct {
      bit          is_wr;
      logic [14:0] addr;
      logic [31:0] data;
   } txn_t;

   typedef struct {
      logic [31:0] cnt_word;
      int          done_after;
      bit          rand_wait;
      bit          toggle;
      logic [31:0] sent;
      bit          go_mid;
      logic [7:0]  exp_count;
      bit          exp_err;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [255:0] bstate_in = '0;
   logic         go = 1'b0;
   logic         busy, done, error, move_valid, move_last;
   logic [7:0]   move_count;
   logic [17:0]  move_data;
   logic         move_ready = 1'b0;
   logic [14:0]  master_address;
   logic         master_read, master_write;
   logic [31:0]  master_writedata;
   logic [31:0]  master_readdata = '0;
   logic         master_waitrequest = 1'b0;
   logic         master_readdatavalid = 1'b0;

   int total = 0;
   int bad = 0;

   txn_t        exp_txn[$];
   logic [18:0] exp_mv[$];
   logic [31:0] mem [0:511];
   int          cfg_done_after = 0;
   int          poll_reads = 0;
   int          poll_base = 0;
   int          done_cnt = 0;
   bit          wait_mode = 0;
   bit          ready_toggle = 0;
   bit          ready_hold = 0;

   bit          pend = 0;
   logic [31:0] pend_data = '0;
   bit          have_prev = 0;
   logic [48:0] prev_cmd = '0;
   txn_t        et;
   logic [18:0] em;

   vec_t vecs [8];

   move_list_fetcher #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT), .MAX_MOVES(MAX_MOVES)) dut (
      .clk(clk), .reset(reset), .bstate_in(bstate_in), .go(go),
      .busy(busy), .done(done), .error(error), .move_count(move_count),
      .move_data(move_data), .move_valid(move_valid), .move_ready(move_ready), .move_last(move_last),
      .master_address(master_address), .master_read(master_read), .master_write(master_write),
      .master_writedata(master_writedata), .master_readdata(master_readdata),
      .master_waitrequest(master_waitrequest), .master_readdatavalid(master_readdatavalid)
   );

   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endfunction

   function automatic logic [17:0] move_word(input int i);
      case (i)
         0: return 18'h00123;
         1: return 18'h00456;
         2: return 18'h3FFFF;
         default: return 18'((i * 32'h2F1B + 32'h55) & 32'h3FFFF);
      endcase
   endfunction

   // Avalon slave: picks waitrequest for the next edge, records accepted commands, answers reads one cycle later.
   always @(negedge clk) begin
      if (!reset) begin
         master_waitrequest   = 1'b0;
         master_readdatavalid = 1'b0;
         master_readdata      = '0;
         pend                 = 0;
         have_prev            = 0;
      end else begin
         if (have_prev)
            check("cmd_hold", {master_read, master_write, master_address, master_writedata}, prev_cmd);
         master_readdatavalid = pend;
         master_readdata      = pend ? pend_data : 32'hA5A5_0000;
         if (pend) check("one_outstanding", {master_read, master_write}, 2'b00);
         pend = 0;
         if (master_read && master_write) begin
            total++;
            bad++;
            $display("FAIL rd_wr_both: got read=1 write=1 want at most one");
         end
         master_waitrequest = wait_mode ? 1'($urandom_range(0, 1)) : 1'b0;
         if ((master_read || master_write) && !master_waitrequest) begin
            if (exp_txn.size() == 0) begin
               total++;
               bad++;
               $display("FAIL txn_extra: got wr=%0b addr=%0d data=%0h want none", master_write, master_address, master_writedata);
            end else begin
               et = exp_txn.pop_front();
               check("txn", {master_write, master_address, master_write ? master_writedata : 32'h0},
                     {et.is_wr, et.addr, et.data});
            end
            if (master_read) begin
               pend = 1;
               if (master_address == 15'd0) begin
                  poll_reads++;
                  pend_data = {30'h0, (cfg_done_after != 0 && (poll_reads - poll_base) >= cfg_done_after), 1'b1};
               end else begin
                  pend_data = (master_address < 15'd512) ? mem[master_address[8:0]] : 32'h0;
               end
            end
            have_prev = 0;
         end else begin
            have_prev = master_read || master_write;
            prev_cmd  = {master_read, master_write, master_address, master_writedata};
         end
      end
   end

   // Stream consumer and done counter.
   always @(negedge clk) begin
      if (!reset) begin
         move_ready = 1'b0;
      end else begin
         if (ready_hold)        move_ready = 1'b0;
         else if (ready_toggle) move_ready = ~move_ready;
         else                   move_ready = 1'b1;
         if (done) done_cnt++;
         if (move_valid && move_ready) begin
            if (exp_mv.size() == 0) begin
               total++;
               bad++;
               $display("FAIL move_extra: got data=%0h last=%0b want none", move_data, move_last);
            end else begin
               em = exp_mv.pop_front();
               check("move", {move_last, move_data}, em);
            end
         end
      end
   end

   task automatic setup_vec(input vec_t v, output logic [255:0] b);
      txn_t t;
      int   n;
      for (int k = 0; k < 8; k++) b[32*k +: 32] = $urandom;
      n = int'(v.exp_count);
      for (int i = 0; i < 300; i++) mem[17+i] = {14'h2A5A, move_word(i)};
      mem[16]   = v.cnt_word;
      mem[17+n] = v.sent;
      exp_txn.delete();
      exp_mv.delete();
      for (int k = 0; k < 8; k++) begin
         t = '{1'b1, 15'(2 + k), b[32*k +: 32]};
         exp_txn.push_back(t);
      end
      t = '{1'b1, 15'd0, 32'h1};
      exp_txn.push_back(t);
      for (int p = 0; p < ((v.done_after == 0) ? TIMEOUT : v.done_after); p++) begin
         t = '{1'b0, 15'd0, 32'h0};
         exp_txn.push_back(t);
      end
      if (v.done_after != 0) begin
         t = '{1'b0, 15'd16, 32'h0};
         exp_txn.push_back(t);
         for (int i = 0; i < n; i++) begin
            t = '{1'b0, 15'(17 + i), 32'h0};
            exp_txn.push_back(t);
            exp_mv.push_back({(i == n - 1), move_word(i)});
         end
         if (SENT_EN) begin
            t = '{1'b0, 15'(17 + n), 32'h0};
            exp_txn.push_back(t);
         end
      end
      t = '{1'b1, 15'd0, 32'h0};
      exp_txn.push_back(t);
      cfg_done_after = v.done_after;
      wait_mode      = v.rand_wait;
      ready_toggle   = v.toggle;
      poll_base      = poll_reads;
   endtask

   task automatic go_pulse(input logic [255:0] b);
      @(negedge clk);
      bstate_in = b;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("busy_after_go", busy, 1'b1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [255:0] b;
      int           base_done, cyc;
      bit           seen;
      setup_vec(v, b);
      base_done = done_cnt;
      go_pulse(b);
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (v.go_mid && cyc == 15) begin
            go = 1'b1;
            bstate_in = ~b;
         end else begin
            go = 1'b0;
         end
         if (done_cnt != base_done) seen = 1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout vec%0d: got no done in %0d cycles want done", idx, cyc);
      end
      repeat (5) @(negedge clk);
      check($sformatf("done_pulses vec%0d", idx), done_cnt - base_done, 1);
      check($sformatf("busy_idle vec%0d", idx), busy, 1'b0);
      check($sformatf("error vec%0d", idx), error, v.exp_err);
      check($sformatf("move_count vec%0d", idx), move_count, v.exp_count);
      check($sformatf("txn_left vec%0d", idx), exp_txn.size(), 0);
      check($sformatf("moves_left vec%0d", idx), exp_mv.size(), 0);
   endtask

   initial begin
      logic [255:0] b;
      int           cyc, base_done;
      vecs[0] = '{32'd3,          2, 1'b0, 1'b0, 32'h0,      1'b0, 8'd3,   1'b0};
      vecs[1] = '{32'd3,          2, 1'b1, 1'b1, 32'h0,      1'b1, 8'd3,   1'b0};
      vecs[2] = '{32'd0,          1, 1'b0, 1'b0, 32'h0,      1'b0, 8'd0,   1'b0};
      vecs[3] = '{32'h3FF,        3, 1'b0, 1'b1, 32'h0,      1'b0, 8'd255, 1'b0};
      vecs[4] = '{32'd3,          0, 1'b0, 1'b0, 32'h0,      1'b0, 8'd0,   1'b1};
      vecs[5] = '{32'd2,          2, 1'b1, 1'b0, 32'hDEAD,   1'b0, 8'd2,   SENT_EN};
      vecs[6] = '{32'd0,          1, 1'b0, 1'b0, 32'h1,      1'b0, 8'd0,   SENT_EN};
      vecs[7] = '{32'hFFFF_0105,  1, 1'b1, 1'b1, 32'h0,      1'b0, 8'd5,   1'b0};

      #1 reset = 1'b0;
      #1;
      check("reset_bus", {master_address, master_read, master_write, master_writedata}, 49'd0);
      check("reset_stream", {busy, done, error, move_count, move_data, move_valid, move_last}, 31'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset while a move is held un-accepted.
      ready_hold = 1;
      setup_vec(vecs[0], b);
      base_done = done_cnt;
      go_pulse(b);
      cyc = 0;
      while (!move_valid && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("mid_reset_reached_move", move_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("mid_reset_bus", {master_address, master_read, master_write, master_writedata}, 49'd0);
      check("mid_reset_stream", {busy, done, error, move_count, move_data, move_valid, move_last}, 31'd0);
      exp_txn.delete();
      exp_mv.delete();
      repeat (3) @(negedge clk);
      check("mid_reset_no_done", done_cnt - base_done, 0);
      reset = 1'b1;
      ready_hold = 0;
      run_vec(vecs[0], 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
